// File: rtl/therm_encoder_pipe_if.sv
// Sample-side and result-side signal bundle for therm_encoder_pipe.
// The encoder takes the slave modport and the producer/consumer takes the master modport.
interface therm_encoder_pipe_if #(
  parameter int BITS = 4
);
  localparam int TW = (1 << BITS) - 1;

  logic            clr;
  logic            in_valid;
  logic [TW-1:0]   in_therm;
  logic            out_valid;
  logic [BITS-1:0] out_code;
  logic            out_err;

  modport master (
    output clr, in_valid, in_therm,
    input  out_valid, out_code, out_err
  );

  modport slave (
    input  clr, in_valid, in_therm,
    output out_valid, out_code, out_err
  );
endinterface

// File: rtl/therm_encoder_pipe.sv
// Three-stage thermometer-to-binary encoder with bubble flagging and optional 2^AVG_LOG2 averaging.
// Optional feature macro: THERM_BUBBLE_FIX_EN (majority-vote bubble filter ahead of the popcount).
module therm_encoder_pipe #(
  parameter int BITS     = 4,
  parameter int AVG_LOG2 = 0
) (
  input  logic                 clk,
  input  logic                 rst,
  therm_encoder_pipe_if.slave  bus
);
  localparam int TW = (1 << BITS) - 1;
  localparam int AW = BITS + AVG_LOG2;
  localparam int CW = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'((1 << AVG_LOG2) - 1);

  function automatic logic [BITS-1:0] popcount(input logic [TW-1:0] w);
    logic [BITS-1:0] n;
    n = '0;
    for (int i = 0; i < TW; i++) begin
      n = n + BITS'(w[i]);
    end
    return n;
  endfunction

  function automatic logic has_bubble(input logic [TW-1:0] w);
    logic b;
    b = 1'b0;
    for (int i = 0; i < TW - 1; i++) begin
      b = b | (w[i+1] & ~w[i]);
    end
    return b;
  endfunction

  // Edges are padded as if comparator -1 always fires and comparator TW never does.
  function automatic logic [TW-1:0] majority_fix(input logic [TW-1:0] w);
    logic [TW+1:0] ext;
    logic [TW-1:0] c;
    ext = {1'b0, w, 1'b1};
    for (int i = 0; i < TW; i++) begin
      c[i] = (ext[i] & ext[i+1]) | (ext[i] & ext[i+2]) | (ext[i+1] & ext[i+2]);
    end
    return c;
  endfunction

  logic [TW-1:0]   th_r;
  logic            va_r;
  logic [BITS-1:0] code_b_r;
  logic            bub_b_r;
  logic            vb_r;
  logic [AW-1:0]   acc_r;
  logic [CW-1:0]   cnt_r;
  logic            sticky_r;
  logic            out_valid_r;
  logic [BITS-1:0] out_code_r;
  logic            out_err_r;

  logic [TW-1:0]   corr_s;
  logic [AW-1:0]   sum_s;
  logic [AW-1:0]   shifted_s;

  // Stage B correction and stage C running sum.
  always_comb begin
    corr_s = '0;
`ifdef THERM_BUBBLE_FIX_EN
    corr_s = majority_fix(th_r);
`else
    corr_s = th_r;
`endif
    sum_s     = acc_r + AW'(code_b_r);
    shifted_s = sum_s >> AVG_LOG2;
  end

  // Stage A: capture the raw sample; a flush drops it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      th_r <= '0;
      va_r <= 1'b0;
    end else begin
      if (bus.in_valid) begin
        th_r <= bus.in_therm;
      end
      va_r <= bus.in_valid & ~bus.clr;
    end
  end

  // Stage B: encode and flag non-monotonic words (flag always uses the raw word).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      code_b_r <= '0;
      bub_b_r  <= 1'b0;
      vb_r     <= 1'b0;
    end else begin
      code_b_r <= popcount(corr_s);
      bub_b_r  <= has_bubble(th_r);
      vb_r     <= va_r & ~bus.clr;
    end
  end

  // Stage C: accumulate, and emit the truncated mean when the group completes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_r       <= '0;
      cnt_r       <= '0;
      sticky_r    <= 1'b0;
      out_valid_r <= 1'b0;
      out_code_r  <= '0;
      out_err_r   <= 1'b0;
    end else if (bus.clr) begin
      acc_r       <= '0;
      cnt_r       <= '0;
      sticky_r    <= 1'b0;
      out_valid_r <= 1'b0;
    end else if (vb_r) begin
      if (cnt_r == CNT_LAST) begin
        out_code_r  <= shifted_s[BITS-1:0];
        out_err_r   <= sticky_r | bub_b_r;
        out_valid_r <= 1'b1;
        acc_r       <= '0;
        cnt_r       <= '0;
        sticky_r    <= 1'b0;
      end else begin
        acc_r       <= sum_s;
        cnt_r       <= cnt_r + CW'(1);
        sticky_r    <= sticky_r | bub_b_r;
        out_valid_r <= 1'b0;
      end
    end else begin
      out_valid_r <= 1'b0;
    end
  end

  assign bus.out_valid = out_valid_r;
  assign bus.out_code  = out_code_r;
  assign bus.out_err   = out_err_r;
endmodule

// File: tb/tb_therm_encoder_pipe.sv
// Drives one stimulus stream into an AVG_LOG2=0 and an AVG_LOG2=2 encoder and checks both
// cycle by cycle against a sample-level reference model.
module tb_therm_encoder_pipe;
  localparam int BITS = 4;
  localparam int TW   = (1 << BITS) - 1;
  localparam int MAXC = 512;

  logic          clk = 1'b0;
  logic          rst;
  logic          clr;
  logic          in_valid;
  logic [TW-1:0] in_therm;

  always #5 clk = ~clk;

  therm_encoder_pipe_if #(.BITS(BITS)) if0 ();
  therm_encoder_pipe_if #(.BITS(BITS)) if1 ();

  assign if0.clr = clr;
  assign if0.in_valid = in_valid;
  assign if0.in_therm = in_therm;
  assign if1.clr = clr;
  assign if1.in_valid = in_valid;
  assign if1.in_therm = in_therm;

  therm_encoder_pipe #(.BITS(BITS), .AVG_LOG2(0)) dut0 (.clk(clk), .rst(rst), .bus(if0));
  therm_encoder_pipe #(.BITS(BITS), .AVG_LOG2(2)) dut1 (.clk(clk), .rst(rst), .bus(if1));

  int checks = 0;
  int failures = 0;

  logic          st_v[MAXC];
  logic          st_c[MAXC];
  logic [TW-1:0] st_w[MAXC];
  int            st_n = 0;

  int grp_sum[2];
  int grp_cnt[2];
  bit grp_err[2];
  int held_code[2];
  bit held_err[2];

  function automatic int ones(input logic [TW-1:0] w);
    int n = 0;
    for (int i = 0; i < TW; i++) n += int'(w[i]);
    return n;
  endfunction

  function automatic int model_code(input logic [TW-1:0] w);
`ifdef THERM_BUBBLE_FIX_EN
    int n = 0;
    for (int i = 0; i < TW; i++) begin
      int lo = (i == 0) ? 1 : int'(w[i-1]);
      int hi = (i == TW - 1) ? 0 : int'(w[i+1]);
      if (lo + hi + int'(w[i]) >= 2) n++;
    end
    return n;
`else
    return ones(w);
`endif
  endfunction

  // A word is monotonic exactly when it equals the clean thermometer of its own popcount.
  function automatic bit model_bubble(input logic [TW-1:0] w);
    int clean = (1 << ones(w)) - 1;
    return int'(w) != clean;
  endfunction

  function automatic logic [TW-1:0] therm_of(input int n);
    return TW'((1 << n) - 1);
  endfunction

  function automatic logic [TW-1:0] rand_word();
    int mode = int'($urandom_range(0, 2));
    logic [TW-1:0] w = therm_of(int'($urandom_range(0, TW)));
    if (mode == 1) w = TW'($urandom);
    if (mode == 2) w = w ^ TW'(1 << $urandom_range(0, TW - 1));
    return w;
  endfunction

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      grp_sum[d] = 0; grp_cnt[d] = 0; grp_err[d] = 1'b0;
      held_code[d] = 0; held_err[d] = 1'b0;
    end
  endtask

  task automatic push(input logic v, input logic [TW-1:0] w, input logic c);
    st_v[st_n] = v; st_w[st_n] = w; st_c[st_n] = c;
    st_n++;
  endtask

  // Called at a negedge with an idle pipeline; plays the queued cycles and checks every negedge.
  task automatic run_stream(input string name);
    for (int i = 0; i < 4; i++) push(1'b0, '0, 1'b0);
    for (int c = 0; c < st_n; c++) begin
      bit ev[2];
      logic av;
      logic [BITS-1:0] ac;
      logic ae;
      int k = c - 1;
      int m = c - 3;
      ev[0] = 1'b0; ev[1] = 1'b0;
      if (k >= 0) begin
        for (int d = 0; d < 2; d++) begin
          int sh = (d == 0) ? 0 : 2;
          if (st_c[k]) begin
            grp_sum[d] = 0; grp_cnt[d] = 0; grp_err[d] = 1'b0;
          end else if (m >= 0 && st_v[m] && !st_c[m] && !st_c[m+1]) begin
            grp_sum[d] += model_code(st_w[m]);
            grp_err[d] = grp_err[d] | model_bubble(st_w[m]);
            grp_cnt[d]++;
            if (grp_cnt[d] == (1 << sh)) begin
              held_code[d] = grp_sum[d] >> sh;
              held_err[d] = grp_err[d];
              ev[d] = 1'b1;
              grp_sum[d] = 0; grp_cnt[d] = 0; grp_err[d] = 1'b0;
            end
          end
        end
      end
      for (int d = 0; d < 2; d++) begin
        av = (d == 0) ? if0.out_valid : if1.out_valid;
        ac = (d == 0) ? if0.out_code : if1.out_code;
        ae = (d == 0) ? if0.out_err : if1.out_err;
        checks += 3;
        if (av !== ev[d]) begin
          failures++;
          $display("FAIL %s dut%0d out_valid cycle %0d: got %b expected %b", name, d, c, av, ev[d]);
        end
        if (ac !== BITS'(held_code[d])) begin
          failures++;
          $display("FAIL %s dut%0d out_code cycle %0d: got %0d expected %0d", name, d, c, ac, held_code[d]);
        end
        if (ae !== held_err[d]) begin
          failures++;
          $display("FAIL %s dut%0d out_err cycle %0d: got %b expected %b", name, d, c, ae, held_err[d]);
        end
      end
      in_valid = st_v[c];
      in_therm = st_w[c];
      clr = st_c[c];
      @(negedge clk);
    end
    st_n = 0;
  endtask

  task automatic test_reset();
    rst = 1'b1; clr = 1'b0; in_valid = 1'b0; in_therm = '0;
    model_reset();
    @(negedge clk);
    checks += 6;
    if (if0.out_valid !== 1'b0 || if1.out_valid !== 1'b0) begin
      failures++; $display("FAIL reset out_valid: got %b/%b expected 0/0", if0.out_valid, if1.out_valid);
    end
    if (if0.out_code !== 4'd0 || if1.out_code !== 4'd0) begin
      failures++; $display("FAIL reset out_code: got %0d/%0d expected 0/0", if0.out_code, if1.out_code);
    end
    if (if0.out_err !== 1'b0 || if1.out_err !== 1'b0) begin
      failures++; $display("FAIL reset out_err: got %b/%b expected 0/0", if0.out_err, if1.out_err);
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_directed_codes();
    push(1'b1, 15'h00FF, 1'b0);
    push(1'b0, 15'h0000, 1'b0);
    push(1'b1, 15'h0000, 1'b0);
    push(1'b1, 15'h7FFF, 1'b0);
    push(1'b1, 15'h00F7, 1'b0);
    push(1'b0, 15'h0000, 1'b0);
    push(1'b1, 15'h0103, 1'b0);
    run_stream("directed");
  endtask

  task automatic test_average_gap();
    push(1'b0, 15'h0000, 1'b1);
    push(1'b1, therm_of(3), 1'b0);
    push(1'b1, therm_of(4), 1'b0);
    push(1'b0, 15'h0000, 1'b0);
    push(1'b0, 15'h0000, 1'b0);
    push(1'b1, therm_of(4), 1'b0);
    push(1'b1, therm_of(5), 1'b0);
    for (int i = 0; i < 3; i++) push(1'b1, therm_of(15), 1'b0);
    push(1'b1, therm_of(14), 1'b0);
    run_stream("average_gap");
  endtask

  task automatic test_clr();
    push(1'b0, 15'h0000, 1'b1);
    push(1'b1, 15'h00F7, 1'b0);
    push(1'b1, therm_of(3), 1'b0);
    for (int i = 0; i < 3; i++) push(1'b0, 15'h0000, 1'b0);
    push(1'b0, 15'h0000, 1'b1);
    for (int i = 0; i < 4; i++) push(1'b1, therm_of(6), 1'b0);
    // A flush right behind in-flight samples must drop them.
    push(1'b1, therm_of(2), 1'b0);
    push(1'b1, therm_of(9), 1'b0);
    push(1'b1, therm_of(7), 1'b1);
    run_stream("clr");
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 150; i++) begin
      push($urandom_range(0, 9) < 7, rand_word(), $urandom_range(0, 29) == 0);
    end
    run_stream("back_to_back");
  endtask

  task automatic test_async_reset();
    push(1'b0, 15'h0000, 1'b1);
    for (int i = 0; i < 4; i++) push(1'b1, therm_of(12), 1'b0);
    push(1'b1, therm_of(5), 1'b0);
    push(1'b1, 15'h00F7, 1'b0);
    run_stream("pre_reset");
    in_valid = 1'b1; in_therm = therm_of(9);
    #2;
    rst = 1'b1;
    #1;
    checks += 4;
    if (if0.out_code !== 4'd0 || if1.out_code !== 4'd0) begin
      failures++; $display("FAIL async_reset out_code: got %0d/%0d expected 0/0", if0.out_code, if1.out_code);
    end
    if (if0.out_err !== 1'b0 || if1.out_err !== 1'b0) begin
      failures++; $display("FAIL async_reset out_err: got %b/%b expected 0/0", if0.out_err, if1.out_err);
    end
    if (if0.out_valid !== 1'b0 || if1.out_valid !== 1'b0) begin
      failures++; $display("FAIL async_reset out_valid: got %b/%b expected 0/0", if0.out_valid, if1.out_valid);
    end
    if (dut1.acc_r !== '0) begin
      failures++; $display("FAIL async_reset acc: got %0d expected 0", dut1.acc_r);
    end
    @(negedge clk);
    rst = 1'b0; in_valid = 1'b0;
    model_reset();
    for (int i = 0; i < 4; i++) push(1'b1, therm_of(9), 1'b0);
    run_stream("post_reset");
  endtask

  initial begin
    test_reset();
    test_directed_codes();
    test_average_gap();
    test_clr();
    test_back_to_back();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, time %0t limit 200000", $time);
    $fatal(1);
  end
endmodule
